// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the cpu_ctrl_fsm sequencer (master) and its fetch, ALU and data-memory partners (slave).
// Handshake: imem_req_o/dmem_req_o stay high with stable address/controls until their ack is high at a
// rising edge, which completes the transfer; alu_start_o is a one-cycle pulse and alu_done_i completes
// the operation at any edge from the start cycle onward.
interface cpu_ctrl_fsm_if #(
    parameter int DATAWIDTH = 32
);
    logic                 imem_req_o;
    logic [DATAWIDTH-1:0] imem_addr_o;
    logic                 imem_ack_i;
    logic [31:0]          imem_data_i;
    logic                 alu_start_o;
    logic                 alu_done_i;
    logic                 dmem_req_o;
    logic                 dmem_we_o;
    logic                 dmem_ack_i;
    logic                 rf_we_o;
    logic                 wb_sel_o;
    logic                 branch_taken_i;

    modport master (
        output imem_req_o, imem_addr_o, alu_start_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o,
        input  imem_ack_i, imem_data_i, alu_done_i, dmem_ack_i, branch_taken_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, alu_start_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o,
        output imem_ack_i, imem_data_i, alu_done_i, dmem_ack_i, branch_taken_i
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on illegal opcodes.
// Optional performance counters (cycles, retired instructions) are enabled by CPU_CTRL_PERF_CNT_EN.
module cpu_ctrl_fsm #(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] PC_RESET  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cpu_ctrl_fsm_if.master       bus,
    output logic [31:0]          instr_o,
    output logic [DATAWIDTH-1:0] pc_o,
    output logic [2:0]           state_o,
    output logic                 retired_o,
    output logic                 trap_o
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [DATAWIDTH-1:0] cyc_cnt_o,
    output logic [DATAWIDTH-1:0] ret_cnt_o
`endif
);
    localparam logic [3:0] ADD_OP  = 4'd0;
    localparam logic [3:0] SUB_OP  = 4'd1;
    localparam logic [3:0] MUL_OP  = 4'd2;
    localparam logic [3:0] DIV_OP  = 4'd3;
    localparam logic [3:0] AND_OP  = 4'd4;
    localparam logic [3:0] OR_OP   = 4'd5;
    localparam logic [3:0] XOR_OP  = 4'd6;
    localparam logic [3:0] ADDI_OP = 4'd7;
    localparam logic [3:0] LW_OP   = 4'd8;
    localparam logic [3:0] SW_OP   = 4'd9;
    localparam logic [3:0] BEQ_OP  = 4'd10;
    localparam logic [3:0] BGT_OP  = 4'd11;
    localparam logic [3:0] BGE_OP  = 4'd12;

    localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q;
    logic                 exec_first_q;
    logic [DATAWIDTH-1:0] pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [3:0]           opcode;
    logic                 op_legal, op_branch, op_lw, op_sw;
    logic [DATAWIDTH-1:0] pc_inc, br_offset;
    logic                 imem_req, alu_start, dmem_req, dmem_we, rf_we, wb_sel, retired, trap;

    assign opcode = instr_q[3:0];
    assign op_lw  = (opcode == LW_OP);
    assign op_sw  = (opcode == SW_OP);

    always_comb begin
        op_legal  = 1'b0;
        op_branch = 1'b0;
        case (opcode)
            ADD_OP, SUB_OP, MUL_OP, DIV_OP, AND_OP, OR_OP, XOR_OP, ADDI_OP, LW_OP, SW_OP: op_legal = 1'b1;
            BEQ_OP, BGT_OP, BGE_OP: begin
                op_legal  = 1'b1;
                op_branch = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
    end

    // Not-taken branches simply fall through to pc+1; the add wraps naturally.
    assign pc_inc    = pc_q + ONE;
    assign br_offset = bus.branch_taken_i ? {{(DATAWIDTH-13){instr_q[31]}}, instr_q[31:19]} : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            run_q        <= 1'b0;
            exec_first_q <= 1'b0;
            pc_q         <= PC_RESET;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            exec_first_q <= (state_q == S_DECODE);
            pc_q         <= pc_d;
            instr_q      <= instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        retired   = 1'b0;
        trap      = 1'b0;
        case (state_q)
            // Fetch waits one cycle after reset release before requesting.
            S_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (bus.imem_ack_i) begin
                        instr_d = bus.imem_data_i;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (op_branch) begin
                    retired = 1'b1;
                    pc_d    = pc_inc + br_offset;
                    state_d = S_FETCH;
                end else begin
                    alu_start = exec_first_q;
                    if (bus.alu_done_i) begin
                        state_d = (op_lw || op_sw) ? S_MEM : S_WB;
                    end
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op_sw;
                if (bus.dmem_ack_i) begin
                    if (op_sw) begin
                        retired = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = op_lw;
                retired = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    // Reset squashes every enable in the reset cycle itself, so an abandoned instruction never commits.
    assign bus.imem_req_o  = imem_req & ~rst_i;
    assign bus.imem_addr_o = pc_q;
    assign bus.alu_start_o = alu_start & ~rst_i;
    assign bus.dmem_req_o  = dmem_req & ~rst_i;
    assign bus.dmem_we_o   = dmem_we & ~rst_i;
    assign bus.rf_we_o     = rf_we & ~rst_i;
    assign bus.wb_sel_o    = wb_sel & ~rst_i;
    assign retired_o       = retired & ~rst_i;
    assign trap_o          = trap & ~rst_i;
    assign instr_o         = instr_q;
    assign pc_o            = pc_q;
    assign state_o         = state_q;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [DATAWIDTH-1:0] cyc_cnt_q, ret_cnt_q;

    // Both counters freeze once trapped so a post-mortem read shows the state at the fault.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (state_q != S_TRAP) begin
            cyc_cnt_q <= cyc_cnt_q + ONE;
            if (retired) begin
                ret_cnt_q <= ret_cnt_q + ONE;
            end
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`else
    // Counter-free build: no extra state or ports.
`endif
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized scoreboard bench for cpu_ctrl_fsm: a phase-level instruction model predicts the state trail,
// retire-cycle controls and next PC; directed cases cover trap, reset abandon and the counters.
module tb_cpu_ctrl_fsm;
    localparam int              DW     = 32;
    localparam logic [DW-1:0]   PC_RST = '0;
    localparam logic [3:0] ADD_OP = 4'd0, DIV_OP = 4'd3, LW_OP = 4'd8, SW_OP = 4'd9;
    localparam logic [3:0] BEQ_OP = 4'd10, BGT_OP = 4'd11, BGE_OP = 4'd12, BAD_OP = 4'd13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if #(.DATAWIDTH(DW)) bus ();
    logic [31:0]   instr_o;
    logic [DW-1:0] pc_o;
    logic [2:0]    state_o;
    logic          retired_o, trap_o;
`ifdef CPU_CTRL_PERF_CNT_EN
    logic [DW-1:0] cyc_cnt_o, ret_cnt_o;
`endif

    cpu_ctrl_fsm #(.DATAWIDTH(DW), .PC_RESET(PC_RST)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .state_o   (state_o),
        .retired_o (retired_o),
        .trap_o    (trap_o)
`ifdef CPU_CTRL_PERF_CNT_EN
        ,
        .cyc_cnt_o (cyc_cnt_o),
        .ret_cnt_o (ret_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues filled by the model, drained by the monitor.
    logic [2:0]    exp_st_q[$];
    logic [DW-1:0] exp_pc_q[$];
    logic [31:0]   exp_ins_q[$];
    logic [2:0]    exp_flag_q[$];
    logic [7:0]    exp_alu_q[$];
    logic [7:0]    exp_dreq_q[$];

    logic [DW-1:0] pc_m;
    int            ret_m;
    logic [DW-1:0] bench_cyc;
    bit            mon_en = 1'b0;
    bit            busy = 1'b0;
    bit            pc_chk = 1'b0;
    logic [DW-1:0] pc_exp;
    logic [7:0]    n_alu, n_dreq;

    always @(posedge clk) begin
        if (rst) bench_cyc <= '0;
        else     bench_cyc <= bench_cyc + 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [12:0] off, input logic [3:0] op);
        logic [31:0] r;
        r = $urandom();
        return {off, r[18:4], op};
    endfunction

    // Phase-level model: FETCH lasts di+1 cycles, DECODE 1, EXEC da+1 (branches 1), MEM dd+1, WB 1.
    task automatic model_push(input logic [31:0] ins, input int di, input int da, input int dd, input bit tk);
        logic [3:0]    op;
        int            off;
        logic [DW-1:0] offv;
        op = ins[3:0];
        repeat (di + 1) exp_st_q.push_back(3'd0);
        exp_st_q.push_back(3'd1);
        if (op == BEQ_OP || op == BGT_OP || op == BGE_OP) begin
            exp_st_q.push_back(3'd2);
            off = int'(ins[31:19]);
            if (off >= 4096) off = off - 8192;
            offv = DW'(off);
            pc_m = pc_m + 1 + (tk ? offv : '0);
            exp_flag_q.push_back(3'b000);
            exp_alu_q.push_back(8'd0);
            exp_dreq_q.push_back(8'd0);
        end else begin
            repeat (da + 1) exp_st_q.push_back(3'd2);
            if (op == LW_OP || op == SW_OP) repeat (dd + 1) exp_st_q.push_back(3'd3);
            if (op != SW_OP) exp_st_q.push_back(3'd4);
            if (op == LW_OP)      exp_flag_q.push_back(3'b110);
            else if (op == SW_OP) exp_flag_q.push_back(3'b001);
            else                  exp_flag_q.push_back(3'b100);
            exp_alu_q.push_back(8'd1);
            exp_dreq_q.push_back((op == LW_OP || op == SW_OP) ? 8'(dd + 1) : 8'd0);
            pc_m = pc_m + 1;
        end
        exp_pc_q.push_back(pc_m);
        exp_ins_q.push_back(ins);
        ret_m++;
    endtask

    // Monitor samples 3 time units after the falling edge, after the drivers have settled.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            busy   = 1'b0;
            pc_chk = 1'b0;
        end else begin
            chk("req_mutex", 64'(($countones({bus.imem_req_o, bus.dmem_req_o, bus.alu_start_o, bus.rf_we_o}) > 1)), 64'd0);
            if (mon_en) begin
                if (pc_chk) begin
                    chk("pc_after_retire", 64'(pc_o), 64'(pc_exp));
                    pc_chk = 1'b0;
                end
                if (!busy && bus.imem_req_o && exp_st_q.size() != 0) begin
                    busy   = 1'b1;
                    n_alu  = 8'd0;
                    n_dreq = 8'd0;
                end
                if (busy) begin
                    if (exp_st_q.size() == 0) chk("state_underflow", 64'(state_o), 64'hFF);
                    else                      chk("state_seq", 64'(state_o), 64'(exp_st_q.pop_front()));
                    if (bus.alu_start_o) n_alu++;
                    if (bus.dmem_req_o)  n_dreq++;
                    if (retired_o) begin
                        if (exp_pc_q.size() == 0) begin
                            chk("retire_underflow", 64'd1, 64'd0);
                        end else begin
                            pc_exp = exp_pc_q.pop_front();
                            chk("retire_flags", 64'({bus.rf_we_o, bus.wb_sel_o, bus.dmem_we_o}), 64'(exp_flag_q.pop_front()));
                            chk("alu_start_cnt", 64'(n_alu), 64'(exp_alu_q.pop_front()));
                            chk("dmem_req_cnt", 64'(n_dreq), 64'(exp_dreq_q.pop_front()));
                            chk("instr_latch", 64'(instr_o), 64'(exp_ins_q.pop_front()));
                            pc_chk = 1'b1;
                        end
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_sig(input int which, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            case (which)
                0:       seen = bus.imem_req_o;
                1:       seen = bus.alu_start_o;
                default: seen = bus.dmem_req_o;
            endcase
            if (seen) break;
            @(negedge clk);
        end
        if (!seen) chk({"timeout_", nm}, 64'd0, 64'd1);
    endtask

    task automatic clear_inputs();
        bus.imem_ack_i = 1'b0;
        bus.alu_done_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        bus.imem_data_i = $urandom();
    endtask

    task automatic run_instr(input logic [31:0] ins, input int di, input int da, input int dd, input bit tk, input bit stray);
        logic [3:0] op;
        op = ins[3:0];
        model_push(ins, di, da, dd, tk);
        wait_sig(0, "imem_req");
        repeat (di) @(negedge clk);
        bus.imem_ack_i     = 1'b1;
        bus.imem_data_i    = ins;
        bus.branch_taken_i = tk;
        bus.alu_done_i     = stray;
        bus.dmem_ack_i     = stray;
        @(negedge clk);
        clear_inputs();
        if (op == BEQ_OP || op == BGT_OP || op == BGE_OP) begin
            @(negedge clk);
        end else begin
            wait_sig(1, "alu_start");
            repeat (da) @(negedge clk);
            bus.alu_done_i = 1'b1;
            @(negedge clk);
            bus.alu_done_i = 1'b0;
            if (op == LW_OP || op == SW_OP) begin
                wait_sig(2, "dmem_req");
                repeat (dd) @(negedge clk);
                bus.dmem_ack_i = 1'b1;
                @(negedge clk);
                bus.dmem_ack_i = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_st_q.size() == 0 && exp_pc_q.size() == 0 && !pc_chk && !busy) break;
        end
        chk("drain_left", 64'(exp_st_q.size() + exp_pc_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("rst_no_commit", 64'({retired_o, bus.rf_we_o, bus.dmem_req_o}), 64'd0);
        repeat (n) @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'(PC_RST));
        chk("rst_instr", 64'(instr_o), 64'd0);
        chk("rst_outputs", 64'({bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.alu_start_o,
                                 bus.rf_we_o, bus.wb_sel_o, retired_o, trap_o}), 64'd0);
`ifdef CPU_CTRL_PERF_CNT_EN
        chk("rst_cyc_cnt", 64'(cyc_cnt_o), 64'd0);
        chk("rst_ret_cnt", 64'(ret_cnt_o), 64'd0);
`endif
        exp_st_q.delete(); exp_pc_q.delete(); exp_ins_q.delete();
        exp_flag_q.delete(); exp_alu_q.delete(); exp_dreq_q.delete();
        pc_m  = PC_RST;
        ret_m = 0;
        rst   = 1'b0;
        #1;
        chk("req_low_at_release", 64'(bus.imem_req_o), 64'd0);
        @(negedge clk);
        #1;
        chk("req_one_cycle_after", 64'(bus.imem_req_o), 64'd1);
`ifdef CPU_CTRL_PERF_CNT_EN
        chk("cyc_cnt_restart", 64'(cyc_cnt_o), 64'd1);
`endif
        mon_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [DW-1:0] cyc0;
        bus.branch_taken_i = 1'b0;
        clear_inputs();
        do_reset(3);

        run_instr(mk(13'd0, ADD_OP), 0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("add_pc", 64'(pc_o), 64'd1);
        run_instr(mk(13'd0, LW_OP), 0, 0, 3, 1'b0, 1'b0);
        repeat (3) run_instr(mk(13'd0, ADD_OP), 0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("pc_before_branch", 64'(pc_o), 64'd5);
        run_instr(mk(13'h1FFF, BEQ_OP), 0, 0, 0, 1'b1, 1'b0);
        drain();
        chk("beq_back_pc", 64'(pc_o), 64'd5);
        run_instr(mk(13'd17, BGE_OP), 0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("bge_fall_pc", 64'(pc_o), 64'd6);
        run_instr(mk(13'd0, DIV_OP), 0, 10, 0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 80; i++) begin
            ins = mk(13'($urandom()), 4'($urandom_range(0, 12)));
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom()), 1'($urandom()));
        end
        drain();
        chk("model_pc_final", 64'(pc_o), 64'(pc_m));
`ifdef CPU_CTRL_PERF_CNT_EN
        chk("cyc_cnt", 64'(cyc_cnt_o), 64'(bench_cyc));
        chk("ret_cnt", 64'(ret_cnt_o), 64'(ret_m));
`endif

        // Illegal opcode: trap after decode and stay quiet under stray handshakes.
        mon_en = 1'b0;
        wait_sig(0, "imem_req_trap");
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = mk(13'd3, BAD_OP);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("trap_decode", 64'(state_o), 64'd1);
        @(negedge clk);
        #1;
        chk("trap_state", 64'({state_o, trap_o}), 64'({3'd5, 1'b1}));
`ifdef CPU_CTRL_PERF_CNT_EN
        cyc0 = cyc_cnt_o;
`else
        cyc0 = '0;
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.imem_ack_i  = 1'($urandom());
            bus.alu_done_i  = 1'($urandom());
            bus.dmem_ack_i  = 1'($urandom());
            bus.imem_data_i = mk(13'd0, ADD_OP);
            #1;
            chk("trap_quiet", 64'({bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.alu_start_o,
                                    bus.rf_we_o, retired_o, trap_o, state_o}), 64'({7'b0000001, 3'd5}));
        end
        clear_inputs();
`ifdef CPU_CTRL_PERF_CNT_EN
        chk("trap_cyc_frozen", 64'(cyc_cnt_o), 64'(cyc0));
`else
        chk("trap_cyc_placeholder", 64'(cyc0), 64'(cyc0 & '0));
`endif
        do_reset(2);
        run_instr(mk(13'd0, ADD_OP), 1, 2, 0, 1'b0, 1'b1);
        drain();
        chk("recover_pc", 64'(pc_o), 64'(PC_RST + 1));

        // Reset while a store waits on the data memory: the store must never complete.
        mon_en = 1'b0;
        wait_sig(0, "imem_req_sw");
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = mk(13'd0, SW_OP);
        @(negedge clk);
        clear_inputs();
        wait_sig(1, "alu_start_sw");
        bus.alu_done_i = 1'b1;
        @(negedge clk);
        bus.alu_done_i = 1'b0;
        wait_sig(2, "dmem_req_sw");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_wait", 64'({bus.dmem_req_o, bus.dmem_we_o, bus.rf_we_o, retired_o}), 64'b1100);
            @(negedge clk);
        end
        bus.dmem_ack_i = 1'b1;
        do_reset(2);
        run_instr(mk(13'd0, ADD_OP), 0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("post_abort_pc", 64'(pc_o), 64'(PC_RST + 1));
`ifdef CPU_CTRL_PERF_CNT_EN
        chk("post_abort_ret_cnt", 64'(ret_cnt_o), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
- REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning PC and perf-counter width.
- REQ-002 SHALL have parameter PC_RESET, default 0, meaning the PC value after reset (word address).
- REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
- REQ-005 SHALL have imem_req_o (out, 1), imem_addr_o (out, DATAWIDTH), imem_ack_i (in, 1) and imem_data_i (in, 32) for instruction fetch.
- REQ-006 SHALL have instr_o (out, 32): the latched current instruction, encoded as offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
- REQ-007 SHALL have alu_start_o (out, 1) and alu_done_i (in, 1): the ALU/MUL/DIV start/done handshake.
- REQ-008 SHALL have dmem_req_o (out, 1), dmem_we_o (out, 1) and dmem_ack_i (in, 1) for data memory.
- REQ-009 SHALL have rf_we_o (out, 1) and wb_sel_o (out, 1; 0 = ALU result, 1 = memory data) for register writeback.
- REQ-010 SHALL have branch_taken_i (in, 1), the comparator result for the current BEQ/BGT/BGE.
- REQ-011 SHALL have pc_o (out, DATAWIDTH), state_o (out, 3), retired_o (out, 1) and trap_o (out, 1).

Function
- REQ-012 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5, encoded on state_o.
- REQ-013 SHALL, in FETCH, hold imem_req_o=1 with imem_addr_o=pc_o until imem_ack_i=1; on the ack cycle latch imem_data_i into instr_o and go to DECODE.
- REQ-014 SHALL spend exactly 1 cycle in DECODE; if the opcode is not one of the *_OP values in opcode.svh (ADD, SUB, MUL, DIV, AND, OR, XOR, ADDI, LW, SW, BEQ, BGT, BGE), go to TRAP, else go to EXEC.
- REQ-015 SHALL, in EXEC for ALU, ADDI, LW and SW, pulse alu_start_o for the first EXEC cycle only and wait for alu_done_i; done may arrive in that same cycle.
- REQ-016 SHALL, on alu_done_i in EXEC, go to WB for ALU/ADDI ops and to MEM for LW/SW.
- REQ-017 SHALL spend exactly 1 cycle in EXEC for BEQ, BGT and BGE, sampling branch_taken_i and then going to FETCH.
- REQ-018 SHALL compute the branch target as pc + 1 + sign-extend(offset[31:19]) when taken and pc + 1 when not, both modulo 2^DATAWIDTH.
- REQ-019 SHALL, in MEM, hold dmem_req_o=1 (dmem_we_o=1 only for SW) until dmem_ack_i; on the ack go to WB for LW, and for SW set pc+1 and go to FETCH.
- REQ-020 SHALL, in WB, assert rf_we_o for exactly 1 cycle with wb_sel_o=1 for LW and 0 otherwise, set pc+1, and go to FETCH.
- REQ-021 SHALL pulse retired_o for 1 cycle on the final cycle of every instruction (the WB cycle, the SW MEM-ack cycle, or the branch EXEC cycle).
- REQ-022 SHALL remain in TRAP with trap_o=1 and all request/enable outputs at 0 until reset.
- REQ-023 SHALL give the zero-wait-state latencies: ALU op 4 cycles, LW 5, SW 4, branch 3.
- REQ-024 SHALL keep imem_req_o, dmem_req_o, alu_start_o and rf_we_o mutually exclusive in every cycle.
- REQ-025 SHALL ignore imem_ack_i, dmem_ack_i and alu_done_i in every state that is not waiting on them.

Reset
- REQ-026 SHALL, with rst_i=1 at a clock edge, set state=FETCH, pc_o=PC_RESET, instr_o=0, the perf counters to 0, and imem_req_o, dmem_req_o, dmem_we_o, alu_start_o, rf_we_o, wb_sel_o, retired_o and trap_o to 0.
- REQ-027 SHALL, when reset occurs mid-instruction (including during a pending memory handshake), abandon the instruction without a register write; imem_req_o is first asserted 1 cycle after rst_i falls.

Configuration
- REQ-028 SHALL, with CPU_CTRL_PERF_CNT_EN defined, add the outputs cyc_cnt_o and ret_cnt_o (DATAWIDTH each); the counters increment every non-reset cycle and every retired_o cycle respectively, wrap at 2^DATAWIDTH, and freeze in TRAP.
- REQ-029 SHALL, without CPU_CTRL_PERF_CNT_EN, omit those ports and counters, with all other behaviour identical.

Verification
- REQ-030 The bench SHALL cover: reset, then ADD with immediate acks and done -> states 0,1,2,4; rf_we_o=1 in the 4th cycle; pc_o 0->1.
- REQ-031 The bench SHALL cover: LW with dmem_ack_i delayed 3 cycles -> dmem_req_o held 4 cycles, wb_sel_o=1, total 8 cycles.
- REQ-032 The bench SHALL cover: BEQ offset=13'h1FFF at pc=5 with taken=1 -> pc_o=5; BGE offset=17 at pc=5 with taken=0 -> pc_o=6.
- REQ-033 The bench SHALL cover: DIV with alu_done_i after 10 cycles -> alu_start_o high 1 cycle only, retired_o pulses once.
- REQ-034 The bench SHALL cover: unused opcode -> TRAP after DECODE, trap_o=1, no requests for 20 cycles; rst_i recovers to pc_o=PC_RESET.
- REQ-035 The bench SHALL cover: rst_i asserted during a SW MEM wait -> no write completes; with CPU_CTRL_PERF_CNT_EN, ret_cnt_o=0 and cyc_cnt_o restarts from 0.
